// File: rtl/fsm_pkg.sv
// Shared types and constants for the tail-light sequencer.
// States, lamp patterns, control-field indices and request decode.
package fsm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        HAZ  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_LEFT,
        REQ_RIGHT,
        REQ_HAZ
    } req_t;

    localparam int IDX_LEFT  = 2;
    localparam int IDX_HAZ   = 1;
    localparam int IDX_RIGHT = 0;

    // Lamp order: LC LB LA RA RB RC
    localparam logic [5:0] PAT_IDLE = 6'b000000;
    localparam logic [5:0] PAT_L1   = 6'b001000;
    localparam logic [5:0] PAT_L2   = 6'b011000;
    localparam logic [5:0] PAT_L3   = 6'b111000;
    localparam logic [5:0] PAT_R1   = 6'b000100;
    localparam logic [5:0] PAT_R2   = 6'b000110;
    localparam logic [5:0] PAT_R3   = 6'b000111;
    localparam logic [5:0] PAT_HAZ  = 6'b111111;

    // Left and right together is treated as a hazard request.
    function automatic req_t decode_req(input logic [2:0] ctl);
        req_t r;
        if (ctl[IDX_HAZ] || (ctl[IDX_LEFT] && ctl[IDX_RIGHT]))
            r = REQ_HAZ;
        else if (ctl[IDX_LEFT])
            r = REQ_LEFT;
        else if (ctl[IDX_RIGHT])
            r = REQ_RIGHT;
        else
            r = REQ_NONE;
        return r;
    endfunction

endpackage

// File: rtl/fsm.sv
// Thunderbird tail-light sequencer: Moore FSM driving six lamps.
// Sweeps left/right, flashes hazard; output decoded from state only.
module fsm
    import fsm_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [2:0] Input,
    output logic [5:0] Output
);

    state_t state;
    state_t state_nxt;
    req_t   req;

    assign req = decode_req(Input);

    always_ff @(posedge clk) begin
        if (clr)
            state <= IDLE;
        else if (en)
            state <= state_nxt;
    end

    // A started sweep ignores left/right changes; only hazard preempts it.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                case (req)
                    REQ_HAZ:   state_nxt = HAZ;
                    REQ_LEFT:  state_nxt = L1;
                    REQ_RIGHT: state_nxt = R1;
                    default:   state_nxt = IDLE;
                endcase
            end
            L1:      state_nxt = (req == REQ_HAZ) ? HAZ : L2;
            L2:      state_nxt = (req == REQ_HAZ) ? HAZ : L3;
            L3:      state_nxt = (req == REQ_HAZ) ? HAZ : IDLE;
            R1:      state_nxt = (req == REQ_HAZ) ? HAZ : R2;
            R2:      state_nxt = (req == REQ_HAZ) ? HAZ : R3;
            R3:      state_nxt = (req == REQ_HAZ) ? HAZ : IDLE;
            HAZ:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Output = PAT_IDLE;
        case (state)
            IDLE:    Output = PAT_IDLE;
            L1:      Output = PAT_L1;
            L2:      Output = PAT_L2;
            L3:      Output = PAT_L3;
            R1:      Output = PAT_R1;
            R2:      Output = PAT_R2;
            R3:      Output = PAT_R3;
            HAZ:     Output = PAT_HAZ;
            default: Output = PAT_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fsm.sv
// Directed bench for the tail-light sequencer.
// Each step clocks one edge and checks the lamp pattern after it.
module tb_fsm;

    logic       clk;
    logic       clr;
    logic       en;
    logic [2:0] Input;
    logic [5:0] Output;

    int n_cmp;
    int n_err;

    fsm dut (
        .clk    (clk),
        .clr    (clr),
        .en     (en),
        .Input  (Input),
        .Output (Output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input string tag, input logic [5:0] exp);
        @(posedge clk);
        #1;
        n_cmp++;
        assert (Output === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, Output, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clr   = 1'b1;
        en    = 1'b1;
        Input = 3'b000;

        step("reset", 6'b000000);
        clr = 1'b0;
        for (int i = 0; i < 7; i++)
            step("idle_hold", 6'b000000);

        // right sweep, repeating
        Input = 3'b001;
        step("right_r1", 6'b000100);
        step("right_r2", 6'b000110);
        step("right_r3", 6'b000111);
        step("right_idle", 6'b000000);
        step("right_r1b", 6'b000100);

        // drop request in R1: sweep completes
        Input = 3'b000;
        step("drop_r2", 6'b000110);
        step("drop_r3", 6'b000111);
        step("drop_idle", 6'b000000);
        step("drop_stay", 6'b000000);

        // left sweep, repeating
        Input = 3'b100;
        step("left_l1", 6'b001000);
        step("left_l2", 6'b011000);
        step("left_l3", 6'b111000);
        step("left_idle", 6'b000000);
        step("left_l1b", 6'b001000);
        step("left_l2b", 6'b011000);

        // en low holds L2
        en = 1'b0;
        step("en_hold0", 6'b011000);
        step("en_hold1", 6'b011000);
        step("en_hold2", 6'b011000);
        en = 1'b1;

        // hazard raised in L2
        Input = 3'b110;
        step("haz_from_l2", 6'b111111);

        Input = 3'b010;
        step("haz010_off", 6'b000000);
        step("haz010_on", 6'b111111);
        step("haz010_off2", 6'b000000);

        Input = 3'b111;
        step("haz111_on", 6'b111111);
        step("haz111_off", 6'b000000);

        Input = 3'b101;
        step("haz101_on", 6'b111111);
        step("haz101_off", 6'b000000);
        step("haz101_on2", 6'b111111);
        step("haz101_off2", 6'b000000);

        // change left to right mid-sweep: left runs out first
        Input = 3'b100;
        step("chg_l1", 6'b001000);
        Input = 3'b001;
        step("chg_l2", 6'b011000);
        step("chg_l3", 6'b111000);
        step("chg_idle", 6'b000000);
        step("chg_r1", 6'b000100);

        // hazard preempts a right sweep in R2
        step("rh_r2", 6'b000110);
        Input = 3'b010;
        step("rh_haz", 6'b111111);
        Input = 3'b000;
        step("rh_idle", 6'b000000);

        // clr in R3
        Input = 3'b001;
        step("clr_r1", 6'b000100);
        step("clr_r2", 6'b000110);
        step("clr_r3", 6'b000111);
        clr = 1'b1;
        step("clr_in_r3", 6'b000000);
        clr = 1'b0;
        step("clr_restart", 6'b000100);

        // clr in HAZ
        Input = 3'b010;
        step("clr_haz_on", 6'b111111);
        clr = 1'b1;
        step("clr_in_haz", 6'b000000);
        clr = 1'b0;
        Input = 3'b001;
        step("clr_haz_restart", 6'b000100);

        // clr wins over en low
        en  = 1'b0;
        clr = 1'b1;
        step("clr_en_low", 6'b000000);
        clr = 1'b0;
        step("en_low_idle", 6'b000000);
        en = 1'b1;
        step("en_back_r1", 6'b000100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
